// File: rtl/riscv_memory_stage_pkg.sv
// Shared constants and types for the memory stage: datapath width, load/store size codes,
// writeback select codes, FSM states, and byte-enable helpers.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_memory_stage_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_RSP = 1'b1
  } state_e;

  // Codes outside b/h/bu/hu behave as full-word accesses.
  function automatic size_e decode_size(input logic [2:0] funct3);
    size_e sz;
    case (funct3)
      LS_B, LS_BU: sz = SZ_B;
      LS_H, LS_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] byte_enable(input size_e sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/riscv_load_extend.sv
// Combinational load-data extraction: picks the byte/half at the registered offset
// and sign- or zero-extends it according to funct3.
module riscv_load_extend
  import riscv_memory_stage_pkg::*;
#(
  parameter int unsigned XLEN = `XLEN
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data_o = rdata_i;
    case (offset_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    half_s = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      LS_B:    data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
      LS_BU:   data_o = {{(XLEN-8){1'b0}}, byte_s};
      LS_H:    data_o = {{(XLEN-16){half_s[15]}}, half_s};
      LS_HU:   data_o = {{(XLEN-16){1'b0}}, half_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/riscv_memory_stage.sv
// Memory stage plus M->W pipeline register with a req/gnt/rvalid data-memory port.
// Optional RISCV_MISALIGN_TRAP_EN: misaligned half/word accesses are squashed and flagged on o_misalign_w.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_memory_stage
  import riscv_memory_stage_pkg::*;
#(
  parameter int unsigned XLEN = `XLEN,
  parameter int unsigned N_RD = 5
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_mem_read_m,
  input  logic            i_mem_write_m,
  input  logic [2:0]      i_funct3_m,
  input  logic [XLEN-1:0] i_alu_result_m,
  input  logic [XLEN-1:0] i_write_data_m,
  input  logic [XLEN-1:0] i_pc_plus_4m,
  input  logic [1:0]      i_result_src_m,
  input  logic [N_RD-1:0] i_rd_m,
  input  logic            i_reg_write_m,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stall_m,
  output logic [XLEN-1:0] o_alu_result_w,
  output logic [XLEN-1:0] o_read_data_w,
  output logic [XLEN-1:0] o_pc_plus_4w,
  output logic [1:0]      o_result_src_w,
  output logic [N_RD-1:0] o_rd_w,
  output logic            o_reg_write_w
`ifdef RISCV_MISALIGN_TRAP_EN
  ,
  output logic            o_misalign_w
`endif
);

  state_e          state_q, state_d;
  logic [1:0]      offset_q;
  logic [XLEN-1:0] alu_result_q, read_data_q, pc_plus_4_q;
  logic [1:0]      result_src_q;
  logic [N_RD-1:0] rd_q;
  logic            reg_write_q;
  logic            misalign_q;

  logic            access_s, misalign_s, req_s, stall_s, load_done_s;
  logic [1:0]      off_s;
  size_e           size_s;
  logic [XLEN-1:0] wdata_s, ext_data_s;

  assign access_s = i_mem_read_m | i_mem_write_m;
  assign off_s    = i_alu_result_m[1:0];
  assign size_s   = decode_size(i_funct3_m);

`ifdef RISCV_MISALIGN_TRAP_EN
  assign misalign_s = access_s & (((size_s == SZ_H) & off_s[0]) |
                                  ((size_s == SZ_W) & (off_s != 2'b00)));
`else
  assign misalign_s = 1'b0;
`endif

  // Handshake decode; a granted store retires immediately, a granted load waits for rvalid.
  always_comb begin
    req_s       = 1'b0;
    stall_s     = 1'b0;
    load_done_s = 1'b0;
    state_d     = state_q;
    case (state_q)
      ST_IDLE: begin
        if (access_s && !misalign_s) begin
          req_s   = i_rstn;
          stall_s = !(i_dmem_gnt && i_mem_write_m);
          state_d = (i_dmem_gnt && !i_mem_write_m) ? ST_WAIT_RSP : ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RSP: begin
        stall_s     = !i_dmem_rvalid;
        load_done_s = i_dmem_rvalid;
        state_d     = i_dmem_rvalid ? ST_IDLE : ST_WAIT_RSP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Replicate the store byte/half so every enabled lane carries it.
  always_comb begin
    case (size_s)
      SZ_B:    wdata_s = {4{i_write_data_m[7:0]}};
      SZ_H:    wdata_s = {2{i_write_data_m[15:0]}};
      default: wdata_s = i_write_data_m;
    endcase
  end

  assign o_dmem_req   = req_s;
  assign o_dmem_we    = i_mem_write_m;
  assign o_dmem_addr  = {i_alu_result_m[XLEN-1:2], 2'b00};
  assign o_dmem_be    = byte_enable(size_s, off_s);
  assign o_dmem_wdata = wdata_s;
  assign o_stall_m    = stall_s;

  riscv_load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata_i  (i_dmem_rdata),
    .offset_i (offset_q),
    .funct3_i (i_funct3_m),
    .data_o   (ext_data_s)
  );

  // FSM state, accepted-offset capture and the W pipeline register (bubble while stalled).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      offset_q     <= 2'b00;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus_4_q  <= '0;
      result_src_q <= 2'b00;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_s && i_dmem_gnt && !i_mem_write_m) begin
        offset_q <= off_s;
      end else begin
        offset_q <= offset_q;
      end
      if (stall_s) begin
        reg_write_q <= 1'b0;
        misalign_q  <= 1'b0;
      end else begin
        alu_result_q <= i_alu_result_m;
        pc_plus_4_q  <= i_pc_plus_4m;
        result_src_q <= i_result_src_m;
        rd_q         <= i_rd_m;
        reg_write_q  <= i_reg_write_m & ~misalign_s;
        misalign_q   <= misalign_s;
      end
      if (load_done_s) begin
        read_data_q <= ext_data_s;
      end else begin
        read_data_q <= read_data_q;
      end
    end
  end

  assign o_alu_result_w = alu_result_q;
  assign o_read_data_w  = read_data_q;
  assign o_pc_plus_4w   = pc_plus_4_q;
  assign o_result_src_w = result_src_q;
  assign o_rd_w         = rd_q;
  assign o_reg_write_w  = reg_write_q;
`ifdef RISCV_MISALIGN_TRAP_EN
  assign o_misalign_w   = misalign_q;
`else
  logic unused_s;
  assign unused_s = misalign_q;
`endif

endmodule
